seq_alu: RTL

//  Clocked, parametrised successor to the combinational 8-bit ALU: registered result and flags, start/done

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - Start/Done operation bus between the sequencer and seq_alu
interface seq_alu_if #(
    parameter int DataWidth = 8,
    parameter int FlagBits  = 4
);
    logic                 Start;
    logic [3:0]           FuncOp;
    logic [DataWidth-1:0] A;
    logic [DataWidth-1:0] B;
    logic [FlagBits-1:0]  IFlags;
    logic                 Busy;
    logic                 Done;
    logic [DataWidth-1:0] Y;
    logic [DataWidth-1:0] YHi;
    logic [FlagBits-1:0]  OFlags;

    modport master (
        output Start, FuncOp, A, B, IFlags,
        input  Busy, Done, Y, YHi, OFlags
    );

    modport slave (
        input  Start, FuncOp, A, B, IFlags,
        output Busy, Done, Y, YHi, OFlags
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ALU with registered flags and iterative unsigned multiply/divide
module seq_alu #(
    parameter int DataWidth = 8,
    parameter int FlagBits  = 4
) (
    input  logic     Clk,
    input  logic     Reset_N,
    seq_alu_if.slave bus
);
    localparam int Msb  = DataWidth - 1;
    localparam int CntW = $clog2(DataWidth);
    localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpSub = 4'h1;
    localparam logic [3:0] OpAnd = 4'h2;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpXor = 4'h4;
    localparam logic [3:0] OpSbc = 4'h5;
    localparam logic [3:0] OpShl = 4'h6;
    localparam logic [3:0] OpShr = 4'h7;
    localparam logic [3:0] OpAsr = 4'h8;
    localparam logic [3:0] OpRol = 4'h9;
    localparam logic [3:0] OpRor = 4'hA;
    localparam logic [3:0] OpMul = 4'hB;
    localparam logic [3:0] OpDiv = 4'hC;
    localparam logic [3:0] OpCmp = 4'hD;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [DataWidth-1:0] opnd_q, opnd_d;
    logic [DataWidth-1:0] hi_q, hi_d;
    logic [DataWidth-1:0] lo_q, lo_d;
    logic [DataWidth-1:0] y_q, y_d;
    logic [DataWidth-1:0] yhi_q, yhi_d;
    logic [FlagBits-1:0]  flags_q, flags_d;

    logic                 cin;
    logic [DataWidth-1:0] add_b;
    logic                 add_k;
    logic [DataWidth:0]   add_full;
    logic [DataWidth-1:0] s_y;
    logic                 s_c;
    logic                 s_v;
    logic [DataWidth:0]   mul_sum;
    logic [DataWidth:0]   div_sh;
    logic [DataWidth:0]   div_diff;
    logic [DataWidth-1:0] step_hi;
    logic [DataWidth-1:0] step_lo;

    function automatic logic [FlagBits-1:0] pack_flags(
        input logic [DataWidth-1:0] y,
        input logic                 c,
        input logic                 v
    );
        logic [FlagBits-1:0] f;
        f    = '0;
        f[3] = v;
        f[2] = y[Msb];
        f[1] = c;
        f[0] = (y == '0);
        return f;
    endfunction

    assign cin = bus.IFlags[1];

    // One adder serves ADD, SUB, SBC and CMP: A + (B or ~B) + k
    always_comb begin
        add_b = bus.B;
        add_k = cin;
        if (bus.FuncOp == OpSub || bus.FuncOp == OpCmp) begin
            add_b = ~bus.B;
            add_k = 1'b1;
        end else if (bus.FuncOp == OpSbc) begin
            add_b = ~bus.B;
        end
        add_full = {1'b0, bus.A} + {1'b0, add_b} + {{DataWidth{1'b0}}, add_k};
    end

    always_comb begin
        s_y = '0;
        s_c = 1'b0;
        s_v = 1'b0;
        case (bus.FuncOp)
            OpAdd: begin
                s_y = add_full[Msb:0];
                s_c = add_full[DataWidth];
                s_v = (bus.A[Msb] == bus.B[Msb]) && (s_y[Msb] != bus.A[Msb]);
            end
            OpSub, OpSbc, OpCmp: begin
                s_y = add_full[Msb:0];
                s_c = add_full[DataWidth];
                s_v = (bus.A[Msb] != bus.B[Msb]) && (s_y[Msb] != bus.A[Msb]);
            end
            OpAnd: s_y = bus.A & bus.B;
            OpOr:  s_y = bus.A | bus.B;
            OpXor: s_y = bus.A ^ bus.B;
            OpShl: begin
                s_y = {bus.A[Msb-1:0], 1'b0};
                s_c = bus.A[Msb];
            end
            OpShr: begin
                s_y = {1'b0, bus.A[Msb:1]};
                s_c = bus.A[0];
            end
            OpAsr: begin
                s_y = {bus.A[Msb], bus.A[Msb:1]};
                s_c = bus.A[0];
            end
            OpRol: begin
                s_y = {bus.A[Msb-1:0], cin};
                s_c = bus.A[Msb];
            end
            OpRor: begin
                s_y = {cin, bus.A[Msb:1]};
                s_c = bus.A[0];
            end
            default: ;
        endcase
    end

    // hi/lo form one double-width register: product accumulator for MUL,
    // remainder/quotient pair for restoring DIV
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {hi_q, lo_q[Msb]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_diff[DataWidth]) begin
                step_hi = div_sh[Msb:0];
                step_lo = {lo_q[Msb-1:0], 1'b0};
            end else begin
                step_hi = div_diff[Msb:0];
                step_lo = {lo_q[Msb-1:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[DataWidth:1];
            step_lo = {mul_sum[0], lo_q[Msb:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        y_d      = y_q;
        yhi_d    = yhi_q;
        flags_d  = flags_q;
        case (state_q)
            StCalc: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    y_d     = step_lo;
                    yhi_d   = step_hi;
                    flags_d = is_div_q ? pack_flags(step_lo, 1'b0, 1'b0)
                                       : pack_flags(step_lo, step_hi != '0, step_hi != '0);
                end
            end
            default: begin
                state_d = StIdle;
                if (bus.Start) begin
                    state_d = StDone;
                    case (bus.FuncOp)
                        OpMul: begin
                            state_d  = StCalc;
                            is_div_d = 1'b0;
                            opnd_d   = bus.A;
                            hi_d     = '0;
                            lo_d     = bus.B;
                            cnt_d    = '0;
                        end
                        OpDiv: begin
                            if (bus.B == '0) begin
                                y_d     = '1;
                                yhi_d   = bus.A;
                                flags_d = pack_flags('1, 1'b0, 1'b1);
                            end else begin
                                state_d  = StCalc;
                                is_div_d = 1'b1;
                                opnd_d   = bus.B;
                                hi_d     = '0;
                                lo_d     = bus.A;
                                cnt_d    = '0;
                            end
                        end
                        OpCmp: flags_d = pack_flags(s_y, s_c, s_v);
                        4'hE, 4'hF: begin
                            y_d   = '0;
                            yhi_d = '0;
                        end
                        default: begin
                            y_d     = s_y;
                            yhi_d   = '0;
                            flags_d = pack_flags(s_y, s_c, s_v);
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            yhi_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            yhi_q    <= yhi_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.Busy   = (state_q == StCalc);
    assign bus.Done   = (state_q == StDone);
    assign bus.Y      = y_q;
    assign bus.YHi    = yhi_q;
    assign bus.OFlags = flags_q;
endmodule
